// File: rtl/mac_feeder.sv
// mac_feeder: upstream sequencer for the bit-serial MAC unit.
//
// Accepts a valid/ready stream of 16-bit operand pairs and loads each pair
// into the MAC input registers. It drives the MAC control byte and handshakes
// with the MAC through START and IRQ_MAC for a programmed number of taps.
// At the end it captures the shifted MAC output and pulses done.
//
// Optional feature: define MAC_FEEDER_TIMEOUT_EN to enable the per-tap
// ARM/WAIT watchdog, which sets err_timeout. Without it err_timeout is tied 0.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   go                1-cycle sequence request (honoured only in IDLE)
//   cfg_taps          taps per sequence, sampled on go
//   cfg_shift         MAC_SHIFTER value, sampled on go
//   s_valid/s_ready   operand stream handshake
//   s_a, s_b          operand pair
//   MAC_INA/MAC_INB   zero-extended operands to the MAC
//   MAC_CTRL          {ON, SHIFT[2:0], MODE=01, START, I_MSK}
//   IRQ_MAC, MAC_OUT  MAC completion level and shifted accumulator
//   busy, done        not-IDLE flag, end-of-sequence pulse
//   result            MAC_OUT captured at sequence end
//   taps_done         taps completed in current/last sequence
//   err_timeout       sticky watchdog error, cleared by an accepted go
module mac_feeder #(
    parameter int TAPS_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [TAPS_W-1:0] cfg_taps,
    input  logic [2:0]        cfg_shift,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [15:0]       s_a,
    input  logic [15:0]       s_b,
    output logic [31:0]       MAC_INA,
    output logic [31:0]       MAC_INB,
    output logic [7:0]        MAC_CTRL,
    input  logic              IRQ_MAC,
    input  logic [15:0]       MAC_OUT,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic [TAPS_W-1:0] taps_done,
    output logic              err_timeout
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_ARM     = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_FIN     = 3'd5;

    logic [2:0]        r_state;
    logic [TAPS_W-1:0] r_taps_cfg;
    logic [TAPS_W-1:0] r_taps_done;
    logic [2:0]        r_shift;
    logic              r_on;
    logic              r_start;
    logic              r_ready;
    logic [15:0]       r_ina;
    logic [15:0]       r_inb;
    logic              r_done;
    logic [15:0]       r_result;
    logic [TAPS_W-1:0] w_taps_next;

`ifdef MAC_FEEDER_TIMEOUT_EN
    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] r_wd;
    logic            r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign w_taps_next = r_taps_done + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_taps_cfg  <= '0;
            r_taps_done <= '0;
            r_shift     <= '0;
            r_on        <= 1'b0;
            r_start     <= 1'b0;
            r_ready     <= 1'b0;
            r_ina       <= '0;
            r_inb       <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
`ifdef MAC_FEEDER_TIMEOUT_EN
            r_wd        <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            // ON and the fixed control fields come up the first cycle after reset.
            r_on   <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        if (cfg_taps != '0) begin
                            r_taps_cfg  <= cfg_taps;
                            r_shift     <= cfg_shift;
                            r_taps_done <= '0;
                            r_ready     <= 1'b1;
                            r_state     <= ST_FETCH;
`ifdef MAC_FEEDER_TIMEOUT_EN
                            r_err       <= 1'b0;
`endif
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (s_valid && r_ready) begin
                        r_ina   <= s_a;
                        r_inb   <= s_b;
                        r_ready <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= ST_ARM;
`ifdef MAC_FEEDER_TIMEOUT_EN
                        r_wd    <= '0;
`endif
                    end
                end
                ST_ARM: begin
                    // Stale IRQ from the previous tap must drop before waiting.
                    if (!IRQ_MAC) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (IRQ_MAC) begin
                        r_start <= 1'b0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_taps_done <= w_taps_next;
                    if (w_taps_next == r_taps_cfg) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    r_result <= MAC_OUT;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_start <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef MAC_FEEDER_TIMEOUT_EN
            // Watchdog overrides the normal ARM/WAIT transitions above.
            if (r_state == ST_ARM || r_state == ST_WAIT) begin
                r_wd <= r_wd + 1'b1;
                if (r_wd == WD_MAX) begin
                    r_start <= 1'b0;
                    r_err   <= 1'b1;
                    r_state <= ST_FIN;
                end
            end
`endif
        end
    end

    assign s_ready     = r_ready;
    assign MAC_INA     = {16'h0000, r_ina};
    assign MAC_INB     = {16'h0000, r_inb};
    assign MAC_CTRL    = {r_on, r_shift, 1'b0, r_on, r_start, r_on};
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign taps_done   = r_taps_done;
`ifdef MAC_FEEDER_TIMEOUT_EN
    assign err_timeout = r_err;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
